// File: rtl/aes_reg_if_p.sv
// aes_reg_if_p: parametrised bus front-end for the AES core.
//
// Decodes key, block, config and control registers from a simple
// cs/we word bus. A small job sequencer issues core init (key expansion)
// only when the key has changed or init is forced, then core next. Each
// finished result is pushed into a result FIFO that software reads through
// a read-only window and discards with a pop strobe.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cs, we, address,        host bus; an access occurs only when cs=1
//   write_data, read_data   read_data is registered and holds between reads
//   irq                     irq_en & (fifo non-empty | err)
//   core_key, core_block    register words concatenated, word 0 in the MSBs
//   core_keylen, core_encdec, core_init, core_next   controls to aes_core
//   core_ready, core_result, core_valid              status from aes_core
module aes_reg_if_p #(
    parameter int DATA_W    = 32,   // 16 or 32
    parameter int RES_DEPTH = 4     // power of two, 2..16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic [7:0]        address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              irq,
    output logic [255:0]      core_key,
    output logic [127:0]      core_block,
    output logic              core_keylen,
    output logic              core_encdec,
    output logic              core_init,
    output logic              core_next,
    input  logic              core_ready,
    input  logic [127:0]      core_result,
    input  logic              core_valid
);
    localparam int NK     = 256 / DATA_W;
    localparam int NB     = 128 / DATA_W;
    localparam int KIDX_W = $clog2(NK);
    localparam int BIDX_W = $clog2(NB);
    localparam int PTR_W  = $clog2(RES_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [7:0] ADDR_CTRL   = 8'h20;
    localparam logic [7:0] ADDR_CONFIG = 8'h21;
    localparam logic [7:0] ADDR_STATUS = 8'h22;

    typedef enum logic [2:0] {IDLE, INIT_P, INIT_W, NEXT_P, NEXT_W, PUSH} state_t;

    state_t             state_q, state_d;
    logic               init_only_q, init_only_d;   // job stops after key expansion
    logic               skip_q, skip_d;             // first wait cycle after a pulse
    logic [127:0]       res_q, res_d;
    logic [DATA_W-1:0]  key_q [NK];
    logic [DATA_W-1:0]  blk_q [NB];
    logic               encdec_q, keylen_q, irq_en_q;
    logic               err_q, key_valid_q;
    logic [DATA_W-1:0]  read_data_q;
    logic [127:0]       fifo_mem [RES_DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;

    // Bus decode
    logic wr, rd, idle, key_hit, blk_hit, res_hit, cfg_wr;
    logic start_s, force_s, pop_s, clr_s;
    logic [KIDX_W-1:0] kidx;
    logic [BIDX_W-1:0] bidx;

    assign wr      = cs & we;
    assign rd      = cs & ~we;
    assign idle    = (state_q == IDLE);
    assign key_hit = (address < 8'(NK));
    assign blk_hit = (address >= 8'h10) && (address < 8'(16 + NB));
    assign res_hit = (address >= 8'h18) && (address < 8'(24 + NB));
    assign cfg_wr  = wr && (address == ADDR_CONFIG);
    assign kidx    = address[KIDX_W-1:0];
    // 0x10 and 0x18 are both aligned to NB, so the low bits give the word
    assign bidx    = address[BIDX_W-1:0];
    assign start_s = wr && (address == ADDR_CTRL) && write_data[0];
    assign force_s = wr && (address == ADDR_CTRL) && write_data[1];
    assign pop_s   = wr && (address == ADDR_CTRL) && write_data[2];
    assign clr_s   = wr && (address == ADDR_CTRL) && write_data[3];

    logic nonempty, full, pop_ok, push, kv_set, start_err, bus_err;
    assign nonempty = (count_q != '0);
    // Only one job is ever in flight and none while IDLE, so the
    // count-plus-in-flight test reduces to the FIFO being full.
    assign full     = (count_q == CNT_W'(RES_DEPTH));
    assign pop_ok   = pop_s && nonempty;
    assign bus_err  = wr && !idle && (key_hit || blk_hit || (address == ADDR_CONFIG) || start_s);

    // Sequencer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            init_only_q <= 1'b0;
            skip_q      <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_only_q <= init_only_d;
            skip_q      <= skip_d;
            res_q       <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_only_d = init_only_q;
        skip_d      = 1'b0;
        res_d       = res_q;
        kv_set      = 1'b0;
        push        = 1'b0;
        start_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    if (full) begin
                        start_err = 1'b1;
                    end else if (!key_valid_q || force_s) begin
                        state_d     = INIT_P;
                        init_only_d = 1'b0;
                    end else begin
                        state_d = NEXT_P;
                    end
                end else if (force_s) begin
                    state_d     = INIT_P;
                    init_only_d = 1'b1;
                end
            end
            INIT_P: begin
                state_d = INIT_W;
                skip_d  = 1'b1;
            end
            INIT_W: begin
                // core_ready may still show the pre-init value on the first cycle
                if (!skip_q && core_ready) begin
                    kv_set  = 1'b1;
                    state_d = init_only_q ? IDLE : NEXT_P;
                end
            end
            NEXT_P: begin
                state_d = NEXT_W;
                skip_d  = 1'b1;
            end
            NEXT_W: begin
                // a stale core_valid from the previous job is masked by skip_q
                if (!skip_q && core_ready && core_valid) begin
                    res_d   = core_result;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_init = (state_q == INIT_P);
    assign core_next = (state_q == NEXT_P);

    // Registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NK; i++) key_q[i] <= '0;
            for (int i = 0; i < NB; i++) blk_q[i] <= '0;
            encdec_q    <= 1'b0;
            keylen_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            if (wr && idle && key_hit) key_q[kidx] <= write_data;
            if (wr && idle && blk_hit) blk_q[bidx] <= write_data;
            if (cfg_wr && idle) begin
                encdec_q <= write_data[0];
                keylen_q <= write_data[1];
                irq_en_q <= write_data[2];
            end
            // a set event in the same cycle as clear_err wins
            if (start_err || bus_err) err_q <= 1'b1;
            else if (clr_s)           err_q <= 1'b0;
            if (kv_set)
                key_valid_q <= 1'b1;
            else if (idle && wr && key_hit)
                key_valid_q <= 1'b0;
            else if (idle && cfg_wr && (write_data[1] != keylen_q))
                key_valid_q <= 1'b0;
        end
    end

    // Result FIFO
    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail_q] <= res_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)   tail_q <= tail_q + 1'b1;
            if (pop_ok) head_q <= head_q + 1'b1;
            case ({push, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Word views of the concatenated outputs and the FIFO head
    logic [127:0]      head_entry;
    logic [DATA_W-1:0] head_words [NB];
    assign head_entry = fifo_mem[head_q];

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_key
            assign core_key[255 - gi*DATA_W -: DATA_W] = key_q[gi];
        end
        for (gi = 0; gi < NB; gi++) begin : g_blk
            assign core_block[127 - gi*DATA_W -: DATA_W] = blk_q[gi];
            assign head_words[gi] = head_entry[127 - gi*DATA_W -: DATA_W];
        end
    endgenerate

    // Read path
    logic [15:0]       status_w;
    logic [DATA_W-1:0] rd_d;
    assign status_w = {8'(count_q), 3'b000, key_valid_q, err_q, full, nonempty, idle};

    always_comb begin
        rd_d = '0;
        if (key_hit)                     rd_d = key_q[kidx];
        else if (blk_hit)                rd_d = blk_q[bidx];
        else if (res_hit)                rd_d = nonempty ? head_words[bidx] : '0;
        else if (address == ADDR_CONFIG) rd_d = DATA_W'({irq_en_q, keylen_q, encdec_q});
        else if (address == ADDR_STATUS) rd_d = DATA_W'(status_w);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  read_data_q <= '0;
        else if (rd)   read_data_q <= rd_d;
    end

    assign read_data   = read_data_q;
    assign irq         = irq_en_q & (nonempty | err_q);
    assign core_keylen = keylen_q;
    assign core_encdec = encdec_q;
endmodule

// File: tb/tb_aes_reg_if_p.sv
// tb_aes_reg_if_p: directed test of aes_reg_if_p at DATA_W=32 (instance a)
// and DATA_W=16 (instance b), each driving a small behavioural core model.
module tb_aes_reg_if_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // instance a: 32-bit bus
    logic        rst_a = 1'b0, cs_a = 1'b0, we_a = 1'b0;
    logic [7:0]  addr_a = '0;
    logic [31:0] wd_a = '0, rd_a;
    logic        irq_a, kl_a, ed_a, init_a, next_a;
    logic [255:0] key_a;
    logic [127:0] blk_a;
    // instance b: 16-bit bus
    logic        rst_b = 1'b0, cs_b = 1'b0, we_b = 1'b0;
    logic [7:0]  addr_b = '0;
    logic [15:0] wd_b = '0, rd_b;
    logic        irq_b, kl_b, ed_b, init_b, next_b;
    logic [255:0] key_b;
    logic [127:0] blk_b;

    // core models (index 0 -> a, 1 -> b)
    logic [1:0]   m_rdy = 2'b11, m_vld = 2'b00, m_job = 2'b00;
    logic [127:0] m_res [2];
    int           m_cnt [2];
    logic [1:0]   m_init, m_next;
    assign m_init = {init_b, init_a};
    assign m_next = {next_b, next_a};

    aes_reg_if_p #(.DATA_W(32), .RES_DEPTH(4)) dut_a (
        .clk(clk), .reset_n(rst_a), .cs(cs_a), .we(we_a), .address(addr_a),
        .write_data(wd_a), .read_data(rd_a), .irq(irq_a), .core_key(key_a),
        .core_block(blk_a), .core_keylen(kl_a), .core_encdec(ed_a),
        .core_init(init_a), .core_next(next_a), .core_ready(m_rdy[0]),
        .core_result(m_res[0]), .core_valid(m_vld[0]));

    aes_reg_if_p #(.DATA_W(16), .RES_DEPTH(4)) dut_b (
        .clk(clk), .reset_n(rst_b), .cs(cs_b), .we(we_b), .address(addr_b),
        .write_data(wd_b), .read_data(rd_b), .irq(irq_b), .core_key(key_b),
        .core_block(blk_b), .core_keylen(kl_b), .core_encdec(ed_b),
        .core_init(init_b), .core_next(next_b), .core_ready(m_rdy[1]),
        .core_result(m_res[1]), .core_valid(m_vld[1]));

    // Known-answer for the FIPS-197 AES-128 vector, a simple mix otherwise
    function automatic logic [127:0] model_res(input logic [255:0] k, input logic [127:0] b);
        if (k[255:128] == FIPS_KEY && k[127:0] == '0 && b == FIPS_PT) return FIPS_CT;
        return b ^ k[255:128] ^ k[127:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_init[i] || m_next[i]) begin
                m_rdy[i] <= 1'b0;
                m_vld[i] <= 1'b0;
                m_cnt[i] <= 5;
                m_job[i] <= m_next[i];
                m_res[i] <= (i == 0) ? model_res(key_a, blk_a) : model_res(key_b, blk_b);
            end else if (!m_rdy[i]) begin
                if (m_cnt[i] == 1) begin
                    m_rdy[i] <= 1'b1;
                    m_vld[i] <= m_job[i];
                end
                m_cnt[i] <= m_cnt[i] - 1;
            end
        end
    end

    int n_init_a = 0, n_next_a = 0, n_init_b = 0, n_next_b = 0;
    always @(posedge clk) begin
        if (init_a) n_init_a <= n_init_a + 1;
        if (next_a) n_next_a <= n_next_a + 1;
        if (init_b) n_init_b <= n_init_b + 1;
        if (next_b) n_next_b <= n_next_b + 1;
    end

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bus_wr(input int inst, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        if (inst == 0) begin cs_a = 1; we_a = 1; addr_a = a; wd_a = d; end
        else           begin cs_b = 1; we_b = 1; addr_b = a; wd_b = d[15:0]; end
        @(negedge clk);
        cs_a = 0; we_a = 0; cs_b = 0; we_b = 0;
        $display("wr  inst=%0d addr=%02h data=%08h", inst, a, d);
    endtask

    task automatic bus_rd(input int inst, input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        if (inst == 0) begin cs_a = 1; we_a = 0; addr_a = a; end
        else           begin cs_b = 1; we_b = 0; addr_b = a; end
        @(negedge clk);
        cs_a = 0; cs_b = 0;
        d = (inst == 0) ? rd_a : {16'h0, rd_b};
        $display("rd  inst=%0d addr=%02h data=%08h", inst, a, d);
    endtask

    task automatic rd_check(input int inst, input logic [7:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus_rd(inst, a, d);
        check(tag, 256'(d), 256'(exp));
    endtask

    task automatic wait_idle(input int inst);
        logic [31:0] s;
        logic ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            bus_rd(inst, 8'h22, s);
            ok = s[0];
        end
        check("wait_idle", 256'(ok), 256'(1));
    endtask

    logic [31:0] ct_w [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    logic [31:0] fk_w [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    logic [31:0] pt_w [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    logic [255:0] exp_key;
    logic [127:0] exp_blk, exp_res;
    int i0, n0;

    initial begin
        // ---------------- reset, DATA_W=32 ----------------
        repeat (3) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        check("rst_irq", 256'(irq_a), 256'(0));
        check("rst_init", 256'({init_a, next_a}), 256'(0));
        rd_check(0, 8'h22, 32'h0000_0001, "rst_status");
        rd_check(0, 8'h21, 32'h0, "rst_config");
        rd_check(0, 8'h18, 32'h0, "rst_result");

        // ---------------- first job: FIPS vector ----------------
        bus_wr(0, 8'h21, 32'h1);
        for (int k = 0; k < 4; k++) bus_wr(0, 8'(k), fk_w[k]);
        for (int k = 0; k < 4; k++) bus_wr(0, 8'(8'h10 + k), pt_w[k]);
        check("core_key32", key_a, {FIPS_KEY, 128'h0});
        check("core_block32", 256'(blk_a), 256'(FIPS_PT));
        check("encdec32", 256'(ed_a), 256'(1));
        rd_check(0, 8'h01, 32'h04050607, "key_readback");
        i0 = n_init_a; n0 = n_next_a;
        bus_wr(0, 8'h20, 32'h1);
        wait_idle(0);
        check("job1_init", 256'(n_init_a - i0), 256'(1));
        check("job1_next", 256'(n_next_a - n0), 256'(1));
        rd_check(0, 8'h22, 32'h0000_0113, "job1_status");
        for (int k = 0; k < 4; k++) rd_check(0, 8'(8'h18 + k), ct_w[k], "job1_result");
        rd_check(0, 8'h20, 32'h0, "ctrl_reads_zero");

        // ---------------- second job, key unchanged ----------------
        i0 = n_init_a; n0 = n_next_a;
        bus_wr(0, 8'h20, 32'h1);
        wait_idle(0);
        check("job2_init", 256'(n_init_a - i0), 256'(0));
        check("job2_next", 256'(n_next_a - n0), 256'(1));
        rd_check(0, 8'h22, 32'h0000_0213, "job2_status");
        bus_wr(0, 8'h20, 32'h4);
        rd_check(0, 8'h22, 32'h0000_0113, "pop_status");
        rd_check(0, 8'h1B, 32'h70b4c55a, "head_after_pop");

        // ---------------- fill FIFO, overflow start ----------------
        for (int k = 0; k < 3; k++) begin
            bus_wr(0, 8'h20, 32'h1);
            wait_idle(0);
        end
        rd_check(0, 8'h22, 32'h0000_0417, "full_status");
        n0 = n_next_a;
        bus_wr(0, 8'h20, 32'h1);
        repeat (10) @(negedge clk);
        check("full_no_next", 256'(n_next_a - n0), 256'(0));
        rd_check(0, 8'h22, 32'h0000_041F, "full_err_status");
        check("irq_disabled", 256'(irq_a), 256'(0));
        bus_wr(0, 8'h21, 32'h5);
        check("irq_on", 256'(irq_a), 256'(1));
        bus_wr(0, 8'h20, 32'h8);
        rd_check(0, 8'h22, 32'h0000_0417, "clear_err_status");
        for (int k = 0; k < 4; k++) bus_wr(0, 8'h20, 32'h4);
        check("irq_drained", 256'(irq_a), 256'(0));
        bus_wr(0, 8'h20, 32'h4);
        rd_check(0, 8'h22, 32'h0000_0011, "pop_empty_status");

        // ---------------- KEY write while busy ----------------
        bus_wr(0, 8'h20, 32'h1);
        bus_wr(0, 8'h00, 32'hdeadbeef);
        wait_idle(0);
        check("busy_key_write", 256'(key_a[255:224]), 256'(32'h00010203));
        rd_check(0, 8'h22, 32'h0000_011B, "busy_err_status");

        // ---------------- DATA_W=16, 256-bit key ----------------
        bus_wr(1, 8'h21, 32'h3);
        for (int k = 0; k < 16; k++) begin
            bus_wr(1, 8'(k), 32'(16'h1000 + k));
            exp_key[255 - 16*k -: 16] = 16'(16'h1000 + k);
        end
        for (int k = 0; k < 8; k++) begin
            bus_wr(1, 8'(8'h10 + k), 32'(16'h2000 + k));
            exp_blk[127 - 16*k -: 16] = 16'(16'h2000 + k);
        end
        check("core_key16", key_b, exp_key);
        check("core_block16", 256'(blk_b), 256'(exp_blk));
        check("keylen16", 256'({kl_b, ed_b}), 256'(2'b11));
        exp_res = exp_blk ^ exp_key[255:128] ^ exp_key[127:0];
        i0 = n_init_b; n0 = n_next_b;
        bus_wr(1, 8'h20, 32'h1);
        wait_idle(1);
        check("job16_init", 256'(n_init_b - i0), 256'(1));
        check("job16_next", 256'(n_next_b - n0), 256'(1));
        rd_check(1, 8'h22, 32'h0000_0113, "job16_status");
        for (int k = 0; k < 8; k++)
            rd_check(1, 8'(8'h18 + k), 32'(exp_res[127 - 16*k -: 16]), "job16_result");

        // ---------------- reset during NEXT_W ----------------
        bus_wr(1, 8'h20, 32'h1);      // FSM now in NEXT_P
        @(negedge clk);               // NEXT_W
        rst_b = 1'b0;
        #1;
        check("rst_mid_pulses", 256'({init_b, next_b}), 256'(0));
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        rd_check(1, 8'h22, 32'h0000_0001, "rst_mid_status");
        repeat (10) @(negedge clk);
        rd_check(1, 8'h22, 32'h0000_0001, "late_valid_ignored");
        rd_check(1, 8'h18, 32'h0, "rst_mid_result");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
